mem_arbiter: RTL and testbench

- Shares one physical memory port (toward cache/memory) between the pipeline's instruction-fetch port (I) and data-memory port (D).
- The D port is the CPU side of the indirect-load sequencer.
- Registered round-robin arbitration. A granted transaction is held until the physical response arrives.
- One idle bubble separates consecutive physical transactions, so the memory always sees request deassertion between accesses.

---
 rtl/lc3b_types.sv | 18 +
 rtl/arb_rr2.sv | 16 +
 rtl/mem_arbiter.sv | 123 ++++++++++++
 tb/tb_mem_arbiter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// lc3b_types: types and constants shared by the memory-path blocks.
//   arb_state_t  - state of the memory-port arbiter (IDLE, I granted, D granted)
//   GRANT_*      - encodings shown on the arbiter's debug grant output
package lc3b_types;

  // The state values match the grant encodings, so a state can be read
  // directly as "who owns the port".
  typedef enum logic [1:0] {
    ARB_IDLE  = 2'b00,
    ARB_GNT_I = 2'b01,
    ARB_GNT_D = 2'b10
  } arb_state_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_I    = 2'b01;
  localparam logic [1:0] GRANT_D    = 2'b10;

endpackage

// File: rtl/arb_rr2.sv
// arb_rr2: two-way round-robin pick between the instruction and data ports.
//   req_i  in  instruction port is requesting
//   req_d  in  data port is requesting
//   last_d in  1 when D owned the port most recently
//   pick_d out 1 when D should be granted next (0 means I, if I requests)
module arb_rr2 (
  input  logic req_i,
  input  logic req_d,
  input  logic last_d,
  output logic pick_d
);

  // D wins when it is alone, or when both request and I was served last.
  assign pick_d = req_d & (~req_i | ~last_d);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one physical memory port between instruction fetch (I)
// and the data port (D, driven by the indirect-load sequencer).
//   clk, reset_n           clock (rising edge), async active-low reset
//   i_read/i_address       I request (level, held until i_resp)
//   i_resp/i_rdata         I response pulse and read data
//   d_read/d_write/...     D request (level, held until d_resp)
//   d_resp/d_rdata         D response pulse and read data
//   p_*                    physical memory port (strobes out, p_resp/p_rdata in)
//   grant                  debug: 00 idle, 01 I, 10 D
// A grant is held until p_resp, and every transaction returns through IDLE,
// so memory always sees its strobes drop between accesses.
module mem_arbiter
  import lc3b_types::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_read,
  input  logic [DATA_W-1:0] i_address,
  output logic              i_resp,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [1:0]        d_wmask,
  input  logic [DATA_W-1:0] d_address,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_resp,
  output logic [DATA_W-1:0] d_rdata,
  output logic              p_read,
  output logic              p_write,
  output logic [1:0]        p_wmask,
  output logic [DATA_W-1:0] p_address,
  output logic [DATA_W-1:0] p_wdata,
  input  logic              p_resp,
  input  logic [DATA_W-1:0] p_rdata,
  output logic [1:0]        grant
);

  arb_state_t state, state_next;
  logic       last_d, last_d_next;
  logic       req_i, req_d, pick_d;

  assign req_i = i_read;
  assign req_d = d_read | d_write;

  arb_rr2 u_rr (
    .req_i  (req_i),
    .req_d  (req_d),
    .last_d (last_d),
    .pick_d (pick_d)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ARB_IDLE;
      last_d <= 1'b0;
    end else begin
      state  <= state_next;
      last_d <= last_d_next;
    end
  end

  // Outputs depend only on the state and the owner's live inputs, so an
  // async reset forcing IDLE zeroes the physical port at once.
  // A dropped request without p_resp is an abort: back to IDLE and the
  // round-robin history is left alone.
  always_comb begin
    state_next  = state;
    last_d_next = last_d;
    grant       = GRANT_NONE;
    p_read      = 1'b0;
    p_write     = 1'b0;
    p_wmask     = 2'b00;
    p_address   = '0;
    p_wdata     = '0;
    i_resp      = 1'b0;
    i_rdata     = '0;
    d_resp      = 1'b0;
    d_rdata     = '0;

    case (state)
      ARB_IDLE: begin
        if (req_i || req_d) begin
          state_next = pick_d ? ARB_GNT_D : ARB_GNT_I;
        end
      end
      ARB_GNT_I: begin
        grant     = GRANT_I;
        p_read    = i_read;
        p_address = i_address;
        i_resp    = p_resp;
        i_rdata   = p_rdata;
        if (p_resp) begin
          state_next  = ARB_IDLE;
          last_d_next = 1'b0;
        end else if (!req_i) begin
          state_next = ARB_IDLE;
        end
      end
      ARB_GNT_D: begin
        grant     = GRANT_D;
        p_read    = d_read;
        p_write   = d_write;
        p_wmask   = d_wmask;
        p_address = d_address;
        p_wdata   = d_wdata;
        d_resp    = p_resp;
        d_rdata   = p_rdata;
        if (p_resp) begin
          state_next  = ARB_IDLE;
          last_d_next = 1'b1;
        end else if (!req_d) begin
          state_next = ARB_IDLE;
        end
      end
      default: begin
        state_next = ARB_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed-vector bench for mem_arbiter.
// Inputs change 1 time unit after a rising edge; outputs are compared one
// more unit later, well away from the next edge.
module tb_mem_arbiter;

  logic        clk;
  logic        reset_n;
  logic        i_read;
  logic [15:0] i_address;
  logic        i_resp;
  logic [15:0] i_rdata;
  logic        d_read;
  logic        d_write;
  logic [1:0]  d_wmask;
  logic [15:0] d_address;
  logic [15:0] d_wdata;
  logic        d_resp;
  logic [15:0] d_rdata;
  logic        p_read;
  logic        p_write;
  logic [1:0]  p_wmask;
  logic [15:0] p_address;
  logic [15:0] p_wdata;
  logic        p_resp;
  logic [15:0] p_rdata;
  logic [1:0]  grant;

  int vectors;
  int miscompares;

  mem_arbiter #(.DATA_W(16)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_read    (i_read),
    .i_address (i_address),
    .i_resp    (i_resp),
    .i_rdata   (i_rdata),
    .d_read    (d_read),
    .d_write   (d_write),
    .d_wmask   (d_wmask),
    .d_address (d_address),
    .d_wdata   (d_wdata),
    .d_resp    (d_resp),
    .d_rdata   (d_rdata),
    .p_read    (p_read),
    .p_write   (p_write),
    .p_wmask   (p_wmask),
    .p_address (p_address),
    .p_wdata   (p_wdata),
    .p_resp    (p_resp),
    .p_rdata   (p_rdata),
    .grant     (grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset holds everything at zero even with I requesting; after release the
  // first edge grants I, and a response is routed to I only.
  task automatic test_reset();
    reset_n = 1'b0; i_read = 1'b1; i_address = 16'h0100;
    d_read = 1'b0; d_write = 1'b0; d_wmask = 2'b00; d_address = '0; d_wdata = '0;
    p_resp = 1'b0; p_rdata = 16'hDEAD;
    #12;
    vectors++; if (p_read !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_p_read: got %b want 0", p_read); end
    vectors++; if (grant !== 2'b00) begin miscompares++; $display("[TB] FAIL reset_grant: got %b want 00", grant); end
    vectors++; if (p_address !== 16'h0000) begin miscompares++; $display("[TB] FAIL reset_p_address: got %h want 0000", p_address); end
    vectors++; if (i_rdata !== 16'h0000 || d_rdata !== 16'h0000) begin miscompares++; $display("[TB] FAIL reset_rdata: got %h/%h want 0000/0000", i_rdata, d_rdata); end
    reset_n = 1'b1;
    tick();
    #1;
    vectors++; if (grant !== 2'b01) begin miscompares++; $display("[TB] FAIL reset_release_grant: got %b want 01", grant); end
    vectors++; if (p_read !== 1'b1 || p_write !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_release_strobe: got r%b w%b want r1 w0", p_read, p_write); end
    vectors++; if (p_address !== 16'h0100) begin miscompares++; $display("[TB] FAIL reset_release_addr: got %h want 0100", p_address); end
    vectors++; if (i_resp !== 1'b0) begin miscompares++; $display("[TB] FAIL i_resp_early: got %b want 0", i_resp); end
    p_rdata = 16'h1234; p_resp = 1'b1;
    #1;
    vectors++; if (i_resp !== 1'b1) begin miscompares++; $display("[TB] FAIL route_i_resp: got %b want 1", i_resp); end
    vectors++; if (i_rdata !== 16'h1234) begin miscompares++; $display("[TB] FAIL route_i_rdata: got %h want 1234", i_rdata); end
    vectors++; if (d_resp !== 1'b0) begin miscompares++; $display("[TB] FAIL route_d_resp: got %b want 0", d_resp); end
    tick();
    i_read = 1'b0; p_resp = 1'b0;
    #1;
    vectors++; if (grant !== 2'b00 || p_read !== 1'b0) begin miscompares++; $display("[TB] FAIL route_idle: got grant %b p_read %b want 00/0", grant, p_read); end
  endtask

  // Both ports request continuously; last_d starts at 0 so D goes first,
  // then strict alternation with an idle cycle between each grant.
  task automatic test_fairness();
    logic       want_d;
    logic [1:0] exp_grant;
    logic [15:0] exp_addr;
    i_read = 1'b1; i_address = 16'h0200;
    d_read = 1'b1; d_address = 16'h0300;
    #1;
    vectors++; if (grant !== 2'b00 || p_read !== 1'b0) begin miscompares++; $display("[TB] FAIL fair_start_idle: got grant %b p_read %b want 00/0", grant, p_read); end
    for (int k = 0; k < 4; k++) begin
      want_d    = (k % 2 == 0);
      exp_grant = want_d ? 2'b10 : 2'b01;
      exp_addr  = want_d ? 16'h0300 : 16'h0200;
      tick();
      vectors++; if (grant !== exp_grant) begin miscompares++; $display("[TB] FAIL fair_grant_%0d: got %b want %b", k, grant, exp_grant); end
      vectors++; if (p_address !== exp_addr || p_read !== 1'b1) begin miscompares++; $display("[TB] FAIL fair_addr_%0d: got %h r%b want %h r1", k, p_address, p_read, exp_addr); end
      tick();
      p_resp = 1'b1; p_rdata = 16'h5000 + 16'(k);
      #1;
      vectors++; if (d_resp !== want_d || i_resp !== !want_d) begin miscompares++; $display("[TB] FAIL fair_resp_%0d: got i%b d%b want i%b d%b", k, i_resp, d_resp, !want_d, want_d); end
      tick();
      p_resp = 1'b0;
      #1;
      vectors++; if (grant !== 2'b00 || p_read !== 1'b0) begin miscompares++; $display("[TB] FAIL fair_bubble_%0d: got grant %b p_read %b want 00/0", k, grant, p_read); end
    end
    i_read = 1'b0; d_read = 1'b0;
    tick();
  endtask

  // D aborts before any response: no d_resp, back to IDLE, and since the
  // round-robin history stays at "I last", the next contention picks D.
  task automatic test_abort();
    d_read = 1'b1; d_address = 16'h4000;
    tick();
    vectors++; if (grant !== 2'b10 || p_read !== 1'b1) begin miscompares++; $display("[TB] FAIL abort_grant: got grant %b p_read %b want 10/1", grant, p_read); end
    d_read = 1'b0;
    #1;
    vectors++; if (p_read !== 1'b0 || d_resp !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_drop: got p_read %b d_resp %b want 0/0", p_read, d_resp); end
    tick();
    vectors++; if (grant !== 2'b00) begin miscompares++; $display("[TB] FAIL abort_idle: got %b want 00", grant); end
    i_read = 1'b1; i_address = 16'h0400; d_read = 1'b1;
    tick();
    vectors++; if (grant !== 2'b10) begin miscompares++; $display("[TB] FAIL abort_next_pick: got %b want 10", grant); end
    p_resp = 1'b1;
    #1;
    vectors++; if (d_resp !== 1'b1 || i_resp !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_next_resp: got i%b d%b want i0 d1", i_resp, d_resp); end
    tick();
    i_read = 1'b0; d_read = 1'b0; p_resp = 1'b0;
    tick();
  endtask

  // Lone D write: all write fields pass through, memory answers on the 3rd
  // granted cycle, d_resp is seen once, then the port sits idle.
  task automatic test_back_to_back();
    int resp_count;
    resp_count = 0;
    d_write = 1'b1; d_wmask = 2'b11; d_address = 16'h3000; d_wdata = 16'hBEEF;
    #1;
    vectors++; if (p_write !== 1'b0 || grant !== 2'b00) begin miscompares++; $display("[TB] FAIL wr_before_grant: got p_write %b grant %b want 0/00", p_write, grant); end
    tick();
    vectors++; if (p_write !== 1'b1 || p_read !== 1'b0) begin miscompares++; $display("[TB] FAIL wr_strobe: got w%b r%b want w1 r0", p_write, p_read); end
    vectors++; if (p_address !== 16'h3000 || p_wdata !== 16'hBEEF || p_wmask !== 2'b11) begin miscompares++; $display("[TB] FAIL wr_fields: got %h/%h/%b want 3000/beef/11", p_address, p_wdata, p_wmask); end
    for (int c = 0; c < 2; c++) begin
      if (d_resp === 1'b1) resp_count++;
      tick();
    end
    p_resp = 1'b1; p_rdata = 16'h0BAD;
    #1;
    if (d_resp === 1'b1) resp_count++;
    vectors++; if (grant !== 2'b10 || p_write !== 1'b1) begin miscompares++; $display("[TB] FAIL wr_held: got grant %b p_write %b want 10/1", grant, p_write); end
    tick();
    d_write = 1'b0; d_wmask = 2'b00; p_resp = 1'b0;
    #1;
    if (d_resp === 1'b1) resp_count++;
    vectors++; if (grant !== 2'b00 || p_write !== 1'b0 || p_wmask !== 2'b00) begin miscompares++; $display("[TB] FAIL wr_bubble: got grant %b w%b mask %b want 00/0/00", grant, p_write, p_wmask); end
    tick();
    if (d_resp === 1'b1) resp_count++;
    vectors++; if (resp_count != 1) begin miscompares++; $display("[TB] FAIL wr_resp_count: got %0d want 1", resp_count); end
    vectors++; if (grant !== 2'b00) begin miscompares++; $display("[TB] FAIL wr_stay_idle: got %b want 00", grant); end
  endtask

  // Reset dropped between edges while D owns the port: everything clears
  // immediately and a late p_resp after release is not forwarded.
  task automatic test_async_reset();
    d_read = 1'b1; d_address = 16'h5000;
    tick();
    vectors++; if (grant !== 2'b10 || p_address !== 16'h5000) begin miscompares++; $display("[TB] FAIL ar_grant: got %b/%h want 10/5000", grant, p_address); end
    #2;
    reset_n = 1'b0;
    #1;
    vectors++; if (p_read !== 1'b0 || p_address !== 16'h0000 || grant !== 2'b00) begin miscompares++; $display("[TB] FAIL ar_clear: got r%b %h grant %b want r0 0000 00", p_read, p_address, grant); end
    p_resp = 1'b1; p_rdata = 16'h7777;
    tick();
    #1;
    reset_n = 1'b1;
    #1;
    vectors++; if (d_resp !== 1'b0 || d_rdata !== 16'h0000) begin miscompares++; $display("[TB] FAIL ar_no_resp: got d_resp %b d_rdata %h want 0/0000", d_resp, d_rdata); end
    d_read = 1'b0; p_resp = 1'b0;
    tick();
    vectors++; if (grant !== 2'b00 || d_resp !== 1'b0) begin miscompares++; $display("[TB] FAIL ar_idle: got grant %b d_resp %b want 00/0", grant, d_resp); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_fairness();
    test_abort();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
